psk_pulse_mod: RTL and testbench

Parametrised phase-coded pulse modulator for the HFSWR transmit chain. It replaces the fixed 16-bit BPSK modulator and its external sync divider. It gates the DDS carrier into repeating pulses, one per pulse repetition interval (PRI). Each pulse is modulated chip-by-chip by a runtime phase code, and the block emits its own pulse-start strobe. The output feeds the DAC output registers at the DDS sample rate.

---
 rtl/psk_pulse_mod.sv | 144 ++++++++++++++
 tb/tb_psk_pulse_mod.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/psk_pulse_mod.sv
// Phase-coded pulse modulator: gates the DDS carrier into PRI-spaced
// pulses, inverting chips per a runtime code, with its own sync strobe.
module psk_pulse_mod #(
  parameter int DW       = 14,
  parameter int CODE_LEN = 16,
  parameter int CW       = 8,
  parameter int PW       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 mode_i,
  input  logic [CODE_LEN-1:0]  code_i,
  input  logic [CW-1:0]        chip_len_i,
  input  logic [PW-1:0]        pri_i,
  input  logic signed [DW-1:0] senial_i,
  output logic signed [DW-1:0] senial_mod_o,
  output logic                 tx_on_o,
  output logic                 sinc_o,
  output logic                 busy_o
);

  localparam int BW = $clog2(CODE_LEN);
  localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] SMAX = ~SMIN;

  typedef enum logic [1:0] {
    IDLE,
    TX,
    GAP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                en_q;
  logic                start;
  logic [CODE_LEN-1:0] code_sh;
  logic [CW-1:0]       chip_l;
  logic [CW-1:0]       chip_cnt;
  logic [PW-1:0]       pri_l;
  logic [PW-1:0]       pri_cnt;
  logic                mode_l;
  logic [BW-1:0]       bit_idx;

  logic pri_wrap;
  logic chip_wrap;
  logic last_chip;

  assign pri_wrap  = pri_cnt == pri_l - PW'(1);
  assign chip_wrap = chip_cnt == chip_l - CW'(1);
  assign last_chip = bit_idx == BW'(CODE_LEN - 1);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_q) begin
          state_d = TX;
          start   = 1'b1;
        end
      end
      TX, GAP: begin
        if (pri_wrap) begin
          if (en_q) begin
            state_d = TX;
            start   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (state_q == TX && chip_wrap && last_chip) begin
          state_d = GAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_i;
    end
  end

  // Code is held as a shift register so the active chip is always the MSB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_sh  <= '0;
      chip_l   <= '0;
      pri_l    <= '0;
      mode_l   <= 1'b0;
      pri_cnt  <= '0;
      chip_cnt <= '0;
      bit_idx  <= '0;
    end else if (start) begin
      code_sh  <= code_i;
      chip_l   <= (chip_len_i == '0) ? CW'(1) : chip_len_i;
      pri_l    <= (pri_i == '0) ? PW'(1) : pri_i;
      mode_l   <= mode_i;
      pri_cnt  <= '0;
      chip_cnt <= '0;
      bit_idx  <= '0;
    end else if (state_q != IDLE) begin
      pri_cnt <= pri_cnt + PW'(1);
      if (state_q == TX) begin
        if (chip_wrap) begin
          chip_cnt <= '0;
          bit_idx  <= bit_idx + BW'(1);
          code_sh  <= code_sh << 1;
        end else begin
          chip_cnt <= chip_cnt + CW'(1);
        end
      end
    end
  end

  logic                 tx;
  logic                 inv;
  logic signed [DW-1:0] neg_sat;

  assign tx      = state_q == TX;
  assign inv     = ~mode_l & code_sh[CODE_LEN-1];
  assign neg_sat = (senial_i == SMIN) ? SMAX : -senial_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      senial_mod_o <= '0;
      tx_on_o      <= 1'b0;
      sinc_o       <= 1'b0;
    end else begin
      senial_mod_o <= tx ? (inv ? neg_sat : senial_i) : '0;
      tx_on_o      <= tx;
      sinc_o       <= tx && (pri_cnt == '0);
    end
  end

  assign busy_o = state_q != IDLE;

endmodule

// File: tb/tb_psk_pulse_mod.sv
// Scoreboard bench for psk_pulse_mod: a timeline model predicts every
// output cycle; a negedge monitor pops and compares.
module tb_psk_pulse_mod;

  localparam int DW = 14;
  localparam int CL = 16;
  localparam int CW = 8;
  localparam int PW = 16;

  logic                 clk;
  logic                 rst;
  logic                 en_i;
  logic                 mode_i;
  logic [CL-1:0]        code_i;
  logic [CW-1:0]        chip_len_i;
  logic [PW-1:0]        pri_i;
  logic signed [DW-1:0] senial_i;
  logic signed [DW-1:0] senial_mod_o;
  logic                 tx_on_o;
  logic                 sinc_o;
  logic                 busy_o;

  psk_pulse_mod #(
    .DW(DW), .CODE_LEN(CL), .CW(CW), .PW(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en_i(en_i),
    .mode_i(mode_i),
    .code_i(code_i),
    .chip_len_i(chip_len_i),
    .pri_i(pri_i),
    .senial_i(senial_i),
    .senial_mod_o(senial_mod_o),
    .tx_on_o(tx_on_o),
    .sinc_o(sinc_o),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int s;
    int tx;
    int sc;
    int bz;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;

  // Model: pulse timeline described by cycles elapsed since pulse start.
  bit            m_en;
  bit            m_run;
  int            m_p;
  logic [CL-1:0] m_code;
  int            m_chip;
  int            m_pri;
  bit            m_mode;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
  endtask

  function automatic int sat_neg(input int s);
    int v;
    v = -s;
    if (v > (1 << (DW - 1)) - 1) v = (1 << (DW - 1)) - 1;
    return v;
  endfunction

  task automatic m_start();
    m_run  = 1'b1;
    m_p    = 0;
    m_code = code_i;
    m_chip = (chip_len_i == 0) ? 1 : int'(chip_len_i);
    m_pri  = (pri_i == 0) ? 1 : int'(pri_i);
    m_mode = mode_i;
  endtask

  task automatic model_edge();
    exp_t e;
    int   chip_no;
    e = '{0, 0, 0, 0};
    if (!rst) begin
      m_en  = 1'b0;
      m_run = 1'b0;
      m_p   = 0;
      q.push_back(e);
      return;
    end
    if (m_run && m_p < CL * m_chip) begin
      chip_no = m_p / m_chip;
      e.tx = 1;
      e.sc = (m_p == 0) ? 1 : 0;
      if (!m_mode && m_code[CL-1-chip_no]) e.s = sat_neg(int'(senial_i));
      else e.s = int'(senial_i);
    end
    if (m_run) begin
      if (m_p == m_pri - 1) begin
        if (m_en) m_start();
        else m_run = 1'b0;
      end else begin
        m_p++;
      end
    end else if (m_en) begin
      m_start();
    end
    m_en = en_i;
    e.bz = m_run ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_phase(input int p, input string name);
    int k;
    k = 0;
    while (!(m_run && m_p == p) && k < 1000) begin
      step();
      k++;
    end
    chk(name, (m_run && m_p == p) ? 1 : 0, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("data", int'(senial_mod_o), e.s);
      chk("tx_on", int'(tx_on_o), e.tx);
      chk("sinc", int'(sinc_o), e.sc);
      chk("busy", int'(busy_o), e.bz);
    end
  end

  initial begin
    rst        = 1'b1;
    en_i       = 1'b1;
    mode_i     = 1'b0;
    code_i     = 16'h0712;
    chip_len_i = 8'd4;
    pri_i      = 16'd100;
    senial_i   = 14'sd1000;
    #1 rst = 1'b0;
    run(5);
    rst = 1'b1;

    run(250);

    code_i   = 16'hFFFF;
    senial_i = -14'sd8192;
    run(200);
    mode_i = 1'b1;
    run(200);

    mode_i     = 1'b0;
    code_i     = 16'h0712;
    senial_i   = 14'sd1000;
    pri_i      = 16'd40;
    run(140);
    chip_len_i = 8'd0;
    run(100);

    chip_len_i = 8'd4;
    pri_i      = 16'd100;
    run(120);
    wait_phase(10, "disarm_reach");
    en_i   = 1'b0;
    run(5);
    code_i = 16'hFFFF;
    run(200);

    code_i = 16'h0712;
    en_i   = 1'b1;
    run(5);
    wait_phase(30, "reset_reach");
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_async_data", int'(senial_mod_o), 0);
    chk("rst_async_tx", int'(tx_on_o), 0);
    chk("rst_async_sinc", int'(sinc_o), 0);
    chk("rst_async_busy", int'(busy_o), 0);
    run(3);
    rst = 1'b1;
    run(150);

    for (int seg = 0; seg < 25; seg++) begin
      int len;
      code_i     = CL'($urandom);
      chip_len_i = CW'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) pri_i = PW'($urandom_range(0, 20));
      else pri_i = PW'($urandom_range(20, 150));
      mode_i = ($urandom_range(0, 3) == 0);
      en_i   = ($urandom_range(0, 4) != 0);
      len    = $urandom_range(30, 300);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) == 0) senial_i = -14'sd8192;
        else senial_i = DW'($urandom);
        if ($urandom_range(0, 19) == 0) code_i = CL'($urandom);
        if ($urandom_range(0, 49) == 0) en_i = ~en_i;
        step();
      end
    end

    en_i = 1'b0;
    run(5);
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
